// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and load/store.
// Optional memory timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned FETCH_MAX_DEFER = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  output logic                if_rsp_err,
  input  logic                ls_req_valid,
  input  logic                ls_req_wr,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_be,
  output logic                ls_req_ready,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_rdata,
  output logic                ls_rsp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned DeferW = $clog2(FETCH_MAX_DEFER + 1);

  // Reject degenerate configurations at elaboration.
  if (FETCH_MAX_DEFER < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: FETCH_MAX_DEFER and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            state_q;
  logic              owner_ls_q;
  logic [DeferW-1:0] defer_q;
  logic              defer_max;

  assign defer_max = (defer_q == DeferW'(FETCH_MAX_DEFER));

  // LS has priority unless IF has already been passed over FETCH_MAX_DEFER times.
  always_comb begin
    ls_req_ready = 1'b0;
    if_req_ready = 1'b0;
    if (!rst && state_q == StIdle) begin
      ls_req_ready = ls_req_valid && !(if_req_valid && defer_max);
      if_req_ready = if_req_valid && !ls_req_ready;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;
  logic            tmo_expired;
  assign tmo_expired = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
  assign if_rsp_err = 1'b0;
  assign ls_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_ls_q   <= 1'b0;
      defer_q      <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_rdata <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      busy         <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q        <= '0;
      if_rsp_err   <= 1'b0;
      ls_rsp_err   <= 1'b0;
`endif
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      if_rsp_err   <= 1'b0;
      ls_rsp_err   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (ls_req_ready) begin
            state_q    <= StAccess;
            owner_ls_q <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= ls_req_wr;
            mem_addr   <= ls_req_addr;
            mem_wdata  <= ls_req_wr ? ls_req_wdata : '0;
            mem_be     <= ls_req_wr ? ls_req_be : '1;
            busy       <= 1'b1;
            if (if_req_valid && !defer_max) defer_q <= defer_q + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q      <= '0;
`endif
          end else if (if_req_ready) begin
            state_q    <= StAccess;
            owner_ls_q <= 1'b0;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_req_addr;
            mem_wdata  <= '0;
            mem_be     <= '1;
            busy       <= 1'b1;
            defer_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q      <= '0;
`endif
          end
        end
        StAccess: begin
          if (mem_ready) begin
            state_q <= StIdle;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            if (owner_ls_q) begin
              ls_rsp_valid <= 1'b1;
              ls_rsp_rdata <= mem_we ? '0 : mem_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rdata;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (tmo_expired) begin
            state_q <= StIdle;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            if (owner_ls_q) begin
              ls_rsp_valid <= 1'b1;
              ls_rsp_rdata <= '0;
              ls_rsp_err   <= 1'b1;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= '0;
              if_rsp_err   <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
